even_odd_gen: RTL and testbench

EVEN_ODD_GEN -- requirements
Module: even_odd_gen

---
 rtl/even_odd_pkg.sv | 13 +
 rtl/even_odd_gen_beat_counter.sv | 28 ++
 rtl/even_odd_gen.sv | 89 ++++++++
 tb/tb_even_odd_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/even_odd_pkg.sv
// Shared definitions for the even/odd word generator and its companion benches.
package even_odd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 4;

endpackage

// File: rtl/even_odd_gen_beat_counter.sv
// Remaining-beat counter: loads the burst length, counts down per transfer,
// and flags the final beat.
module beat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] remaining;

  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= load_val;
    end else if (dec && (remaining != '0)) begin
      remaining <= remaining - 1'b1;
    end
  end

  assign last = (remaining == CNT_W'(1));

endmodule

// File: rtl/even_odd_gen.sv
// Burst generator of consecutive even or odd words with valid/ready handshake
// and a one-cycle done pulse at the end of each burst.
module even_odd_gen
  import even_odd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              want_odd,
  input  logic [DATA_W-1:0] start_val,
  input  logic [CNT_W-1:0]  count,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done
);

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              xfer;
  logic              last;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (count != '0) ? SEND : DONE;
        end
      end
      SEND: begin
        if (out_ready) begin
          xfer = 1'b1;
          if (last) begin
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Parity lives in bit 0 of the word; stepping by 2 never disturbs it,
  // so the latched want_odd is simply data_q[0] for the whole burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (accept) begin
      data_q <= (start_val & ~DATA_W'(1)) | DATA_W'(want_odd);
    end else if (xfer) begin
      data_q <= data_q + DATA_W'(2);
    end
  end

  beat_counter #(
    .CNT_W(CNT_W)
  ) u_beat_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .load_val(count),
    .dec     (xfer),
    .last    (last)
  );

  assign out_valid = (state == SEND);
  assign done      = (state == DONE);
  assign busy      = (state != IDLE);
  assign data_out  = data_q;

endmodule

// File: tb/tb_even_odd_gen.sv
// Scoreboard bench for even_odd_gen: bursts queue their expected words and done
// marker; a negedge monitor pops and compares whenever the DUT transfers or finishes.
module tb_even_odd_gen;

  typedef struct packed {
    logic       is_done;
    logic [7:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       want_odd;
  logic [7:0] start_val;
  logic [3:0] count;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] data_out;
  logic       busy;
  logic       done;

  int   total    = 0;
  int   bad      = 0;
  int   done_cnt = 0;
  int   popped   = 0;
  bit   rand_rdy = 1'b0;
  bit   rdy_q[$];
  exp_t exp_q[$];
  logic hold_chk = 1'b0;
  logic [7:0] held;

  even_odd_gen #(.DATA_W(8), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .want_odd (want_odd),
    .start_val(start_val),
    .count    (count),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge and drive this cycle's inputs.
  // Spurious starts with junk fields are driven while burst d0 is still running.
  task automatic tick(input int d0);
    @(posedge clk);
    #1;
    if (rdy_q.size() != 0) out_ready = rdy_q.pop_front();
    else if (rand_rdy)     out_ready = ($urandom_range(0, 3) != 0);
    else                   out_ready = 1'b1;
    if (done_cnt == d0) begin
      start     = ($urandom_range(0, 2) == 0);
      want_odd  = 1'($urandom);
      start_val = 8'($urandom);
      count     = 4'($urandom);
    end else begin
      start = 1'b0;
    end
  endtask

  // Reference: a burst is cnt words first, first+2, ... (mod 256) then one done.
  task automatic push_burst(input bit wo, input logic [7:0] sv, input logic [3:0] cn,
                            input bit with_done);
    exp_t e;
    logic [7:0] first;
    first = {sv[7:1], wo};
    for (int i = 0; i < int'(cn); i++) begin
      e.is_done = 1'b0;
      e.d       = 8'(int'(first) + 2 * i);
      exp_q.push_back(e);
    end
    if (with_done) begin
      e.is_done = 1'b1;
      e.d       = 8'h00;
      exp_q.push_back(e);
    end
  endtask

  // Caller must be in an IDLE cycle; start is presented in this same cycle.
  task automatic run_burst(input bit wo, input logic [7:0] sv, input logic [3:0] cn);
    int d0;
    int n;
    push_burst(wo, sv, cn, 1'b1);
    d0        = done_cnt;
    start     = 1'b1;
    want_odd  = wo;
    start_val = sv;
    count     = cn;
    tick(d0);
    @(negedge clk);
    if (cn == 4'd0) begin
      check("zero_done", done, 1);
      check("zero_busy", busy, 1);
      check("zero_valid", out_valid, 0);
    end else begin
      check("first_valid", out_valid, 1);
      check("first_word", data_out, {sv[7:1], wo});
      check("first_busy", busy, 1);
    end
    n = 0;
    do begin
      tick(d0);
      n++;
    end while (done_cnt == d0 && n < 600);
    check("burst_end", done_cnt, d0 + 1);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_valid", out_valid, 0);
  endtask

  // Monitor: compare every transfer and done pulse against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      hold_chk = 1'b0;
    end else begin
      check("valid_done_excl", out_valid & done, 0);
      if (hold_chk) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", data_out, held);
      end
      hold_chk = out_valid && !out_ready;
      held     = data_out;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("word_kind", e.is_done, 0);
          check("word", data_out, e.d);
        end
        popped++;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("extra_done", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("done_kind", e.is_done, 1);
        end
        done_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int n;
    reset     = 1'b1;
    start     = 1'b1;
    want_odd  = 1'b1;
    start_val = 8'hAB;
    count     = 4'd3;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_data", data_out, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;

    // Directed bursts: plain, wrapping, ready-throttled, empty.
    run_burst(1'b0, 8'h05, 4'd3);
    run_burst(1'b1, 8'hFC, 4'd3);
    rdy_q = '{1, 0, 0, 1, 1, 0, 1};
    run_burst(1'b0, 8'h40, 4'd4);
    run_burst(1'b1, 8'h10, 4'd0);
    run_burst(1'b0, 8'hFE, 4'd2);

    // Abort a 5-word burst by reset after its 2nd transfer.
    push_burst(1'b1, 8'h20, 4'd5, 1'b0);
    rdy_q     = '{1, 1, 0, 0, 0, 0};
    start     = 1'b1;
    want_odd  = 1'b1;
    start_val = 8'h20;
    count     = 4'd5;
    p0        = popped;
    n         = 0;
    do begin
      tick(-1);
      n++;
    end while (popped < p0 + 2 && n < 100);
    check("pre_abort_words", popped, p0 + 2);
    reset = 1'b1;
    exp_q.delete();
    rdy_q.delete();
    tick(-1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_data", data_out, 8'h00);
    repeat (3) tick(-1);
    run_burst(1'b1, 8'h20, 4'd5);

    // Randomized bursts with random backpressure.
    rand_rdy = 1'b1;
    for (int b = 0; b < 40; b++) begin
      run_burst(1'($urandom), 8'($urandom), 4'($urandom));
    end
    rand_rdy = 1'b0;
    repeat (3) tick(-1);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
